// File: rtl/enc_pkg.sv
// Shared definitions for the rotary encoder front end: Gray-coded phase
// states, the per-transition direction code, and the transition classifier.
package enc_pkg;

  // Phase states {A,B}. The clockwise order is REST -> S1 -> S2 -> S3 -> REST.
  localparam logic [1:0] ENC_REST = 2'b11;
  localparam logic [1:0] ENC_S1   = 2'b01;
  localparam logic [1:0] ENC_S2   = 2'b00;
  localparam logic [1:0] ENC_S3   = 2'b10;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2,
    DIR_ERR  = 2'd3
  } enc_dir_e;

  // Next phase state one clockwise transition after s.
  function automatic logic [1:0] enc_next_cw(input logic [1:0] s);
    logic [1:0] n;
    unique case (s)
      ENC_REST: n = ENC_S1;
      ENC_S1:   n = ENC_S2;
      ENC_S2:   n = ENC_S3;
      default:  n = ENC_REST;
    endcase
    return n;
  endfunction

  // Classify a {last, current} phase pair. Both bits changing is an error.
  function automatic enc_dir_e enc_dir(input logic [1:0] last, input logic [1:0] cur);
    enc_dir_e d;
    if (cur == last)                   d = DIR_NONE;
    else if (cur == enc_next_cw(last)) d = DIR_CW;
    else if (last == enc_next_cw(cur)) d = DIR_CCW;
    else                               d = DIR_ERR;
    return d;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a stable-level debouncer.
// OUT_DB follows IN_RAW only after the synchronised level has differed from
// OUT_DB for DEBOUNCE_CYCLES consecutive cycles.
//   CLOCK_50 : clock, rising edge
//   RESET_N  : synchronous active-low reset (sync and output reset high)
//   IN_RAW   : asynchronous raw pin
//   OUT_DB   : debounced level
module debounce_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic IN_RAW,
  output logic OUT_DB
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             db;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then count consecutive cycles of disagreement with db.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      db    <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= IN_RAW;
      sync2 <= sync1;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign OUT_DB = db;

endmodule

// File: rtl/rotary_encoder_input.sv
// Rotary encoder and push-switch conditioning for clock set controls.
// Debounces A/B/SW, decodes quadrature into one pulse per detent and keeps a
// wrap-around set value in 0..MAX_VAL.
//   CLOCK_50, RESET_N   : clock and synchronous active-low reset
//   ENC_A, ENC_B, ENC_SW: raw asynchronous encoder pins (idle high)
//   LOAD_EN, LOAD_VAL   : load VALUE (clamped to MAX_VAL), beats any step
//   STEP_UP, STEP_DOWN  : one-cycle pulse per CW / CCW detent
//   PRESS, HELD         : switch press pulse and debounced pressed level
//   QERR                : one-cycle pulse on an illegal A/B transition
//   VALUE               : current set value
module rotary_encoder_input
  import enc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned DETENT_STEPS    = 4,
  parameter int unsigned MAX_VAL         = 59,
  parameter int unsigned VAL_W           = 8
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             ENC_A,
  input  logic             ENC_B,
  input  logic             ENC_SW,
  input  logic             LOAD_EN,
  input  logic [VAL_W-1:0] LOAD_VAL,
  output logic             STEP_UP,
  output logic             STEP_DOWN,
  output logic             PRESS,
  output logic             HELD,
  output logic             QERR,
  output logic [VAL_W-1:0] VALUE
);

  // Accumulator must hold +/-DETENT_STEPS as a signed value.
  localparam int unsigned ACC_W = $clog2(DETENT_STEPS) + 2;
  localparam logic signed [ACC_W-1:0] ACC_MAX = $signed(ACC_W'(DETENT_STEPS));
  localparam logic signed [ACC_W-1:0] ACC_ONE = $signed(ACC_W'(1));
  localparam logic [VAL_W-1:0] VAL_MAX = VAL_W'(MAX_VAL);

  logic a_db;
  logic b_db;
  logic sw_db;

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .IN_RAW   (ENC_A),
    .OUT_DB   (a_db)
  );

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .IN_RAW   (ENC_B),
    .OUT_DB   (b_db)
  );

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sw (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .IN_RAW   (ENC_SW),
    .OUT_DB   (sw_db)
  );

  logic [1:0]              last_q;
  logic signed [ACC_W-1:0] acc_q;
  logic                    sw_q;
  logic                    step_up_q;
  logic                    step_dn_q;
  logic                    press_q;
  logic                    held_q;
  logic                    qerr_q;
  logic [VAL_W-1:0]        value_q;

  logic [1:0]              cur;
  enc_dir_e                dir;
  logic signed [ACC_W-1:0] acc_step;
  logic signed [ACC_W-1:0] acc_nxt;
  logic                    step_up_nxt;
  logic                    step_dn_nxt;
  logic                    qerr_nxt;
  logic [VAL_W-1:0]        value_nxt;

  // Quadrature accumulation, detent detection and set-value update.
  always_comb begin
    cur         = {a_db, b_db};
    dir         = enc_dir(last_q, cur);
    acc_step    = acc_q;
    acc_nxt     = acc_q;
    step_up_nxt = 1'b0;
    step_dn_nxt = 1'b0;
    qerr_nxt    = 1'b0;
    value_nxt   = value_q;

    unique case (dir)
      DIR_CW, DIR_CCW: begin
        acc_step = (dir == DIR_CW) ? (acc_q + ACC_ONE) : (acc_q - ACC_ONE);
        if (acc_step == ACC_MAX) begin
          step_up_nxt = 1'b1;
          acc_nxt     = '0;
        end else if (acc_step == -ACC_MAX) begin
          step_dn_nxt = 1'b1;
          acc_nxt     = '0;
        end else if (cur == ENC_REST) begin
          // Back at rest after a partial turn: resynchronise.
          acc_nxt = '0;
        end else begin
          acc_nxt = acc_step;
        end
      end
      DIR_ERR: begin
        qerr_nxt = 1'b1;
        acc_nxt  = '0;
      end
      default: ;
    endcase

    if (LOAD_EN) begin
      value_nxt = (LOAD_VAL > VAL_MAX) ? VAL_MAX : LOAD_VAL;
    end else if (step_up_nxt) begin
      value_nxt = (value_q == VAL_MAX) ? '0 : value_q + VAL_W'(1);
    end else if (step_dn_nxt) begin
      value_nxt = (value_q == '0) ? VAL_MAX : value_q - VAL_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      last_q    <= ENC_REST;
      acc_q     <= '0;
      sw_q      <= 1'b1;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      press_q   <= 1'b0;
      held_q    <= 1'b0;
      qerr_q    <= 1'b0;
      value_q   <= '0;
    end else begin
      last_q    <= cur;
      acc_q     <= acc_nxt;
      sw_q      <= sw_db;
      step_up_q <= step_up_nxt;
      step_dn_q <= step_dn_nxt;
      press_q   <= sw_q & ~sw_db;
      held_q    <= ~sw_db;
      qerr_q    <= qerr_nxt;
      value_q   <= value_nxt;
    end
  end

  assign STEP_UP   = step_up_q;
  assign STEP_DOWN = step_dn_q;
  assign PRESS     = press_q;
  assign HELD      = held_q;
  assign QERR      = qerr_q;
  assign VALUE     = value_q;

endmodule

// File: tb/tb_rotary_encoder_input.sv
// Directed bench for rotary_encoder_input with a short debounce window.
module tb_rotary_encoder_input;

  localparam int unsigned VAL_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enc_a = 1'b1;
  logic             enc_b = 1'b1;
  logic             enc_sw = 1'b1;
  logic             load_en = 1'b0;
  logic [VAL_W-1:0] load_val = '0;
  logic             step_up;
  logic             step_down;
  logic             press;
  logic             held;
  logic             qerr;
  logic [VAL_W-1:0] value;

  int tests = 0;
  int fails = 0;
  int n_up = 0, n_dn = 0, n_press = 0, n_qerr = 0;
  int up0, dn0, pr0, qe0;

  rotary_encoder_input #(
    .DEBOUNCE_CYCLES (4),
    .DETENT_STEPS    (4),
    .MAX_VAL         (59),
    .VAL_W           (VAL_W)
  ) dut (
    .CLOCK_50  (clk),
    .RESET_N   (rst_n),
    .ENC_A     (enc_a),
    .ENC_B     (enc_b),
    .ENC_SW    (enc_sw),
    .LOAD_EN   (load_en),
    .LOAD_VAL  (load_val),
    .STEP_UP   (step_up),
    .STEP_DOWN (step_down),
    .PRESS     (press),
    .HELD      (held),
    .QERR      (qerr),
    .VALUE     (value)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (step_up)   n_up++;
    if (step_down) n_dn++;
    if (press)     n_press++;
    if (qerr)      n_qerr++;
  end

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ab(input logic [1:0] s, input int hold);
    enc_a = s[1];
    enc_b = s[0];
    step_clk(hold);
  endtask

  task automatic snap();
    up0 = n_up;
    dn0 = n_dn;
    pr0 = n_press;
    qe0 = n_qerr;
  endtask

  task automatic detent_cw();
    set_ab(2'b01, 10);
    set_ab(2'b00, 10);
    set_ab(2'b10, 10);
    set_ab(2'b11, 10);
  endtask

  task automatic detent_ccw();
    set_ab(2'b10, 10);
    set_ab(2'b00, 10);
    set_ab(2'b01, 10);
    set_ab(2'b11, 10);
  endtask

  task automatic do_load(input int v);
    load_val = VAL_W'(v);
    load_en  = 1'b1;
    step_clk(1);
    load_en  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step_clk(3);
    check("rst_value", value, 0);
    check("rst_step_up", step_up, 0);
    check("rst_step_down", step_down, 0);
    check("rst_held", held, 0);
    check("rst_qerr", qerr, 0);
    rst_n = 1'b1;
    step_clk(10);

    // 1: one clockwise detent, with exact pulse timing
    snap();
    set_ab(2'b01, 10);
    set_ab(2'b00, 10);
    set_ab(2'b10, 10);
    set_ab(2'b11, 6);
    check("t1_pre_edge6", step_up, 0);
    step_clk(1);
    check("t1_edge7_up", step_up, 1);
    check("t1_edge7_value", value, 1);
    step_clk(1);
    check("t1_edge8_up", step_up, 0);
    step_clk(10);
    check("t1_up_count", n_up - up0, 1);
    check("t1_dn_count", n_dn - dn0, 0);
    check("t1_value", value, 1);

    // 2: wrap up from 59, then wrap down from 0
    do_load(59);
    check("t2_load59", value, 59);
    snap();
    detent_cw();
    check("t2_wrap_up", value, 0);
    detent_ccw();
    check("t2_wrap_down", value, 59);
    check("t2_up_count", n_up - up0, 1);
    check("t2_dn_count", n_dn - dn0, 1);

    // 3a: 3-cycle glitch on A is filtered
    snap();
    enc_a = 1'b0;
    step_clk(3);
    enc_a = 1'b1;
    step_clk(15);
    check("t3_glitch_up", n_up - up0, 0);
    check("t3_glitch_dn", n_dn - dn0, 0);
    check("t3_glitch_qerr", n_qerr - qe0, 0);
    check("t3_glitch_value", value, 59);

    // 3b: switch bounce then a firm press, then release
    for (int i = 0; i < 10; i++) begin
      enc_sw = (i % 2 == 0) ? 1'b0 : 1'b1;
      step_clk(2);
    end
    check("t3_bounce_press", n_press - pr0, 0);
    enc_sw = 1'b0;
    step_clk(10);
    check("t3_press_count", n_press - pr0, 1);
    check("t3_held_on", held, 1);
    enc_sw = 1'b1;
    step_clk(10);
    check("t3_held_off", held, 0);
    check("t3_no_release_press", n_press - pr0, 1);

    // 4: half turn and back, then a full detent
    snap();
    set_ab(2'b01, 10);
    set_ab(2'b00, 10);
    set_ab(2'b01, 10);
    set_ab(2'b11, 10);
    check("t4_half_up", n_up - up0, 0);
    check("t4_half_dn", n_dn - dn0, 0);
    check("t4_half_value", value, 59);
    detent_cw();
    check("t4_full_up", n_up - up0, 1);
    check("t4_full_value", value, 0);

    // 5: illegal jump 11->00, legal return, clamped load
    snap();
    set_ab(2'b00, 10);
    check("t5_qerr_count", n_qerr - qe0, 1);
    set_ab(2'b01, 10);
    set_ab(2'b11, 10);
    check("t5_qerr_total", n_qerr - qe0, 1);
    check("t5_up", n_up - up0, 0);
    check("t5_dn", n_dn - dn0, 0);
    check("t5_value", value, 0);
    do_load(200);
    check("t5_clamp", value, 59);

    // 6a: load coincides with a step: load wins, step pulse still fires
    snap();
    set_ab(2'b01, 10);
    set_ab(2'b00, 10);
    set_ab(2'b10, 10);
    set_ab(2'b11, 6);
    load_val = VAL_W'(30);
    load_en  = 1'b1;
    step_clk(1);
    load_en  = 1'b0;
    check("t6_up_pulse", step_up, 1);
    check("t6_load_vs_step", value, 30);
    step_clk(5);
    check("t6_value_hold", value, 30);
    check("t6_up_count", n_up - up0, 1);

    // 6b: reset in the middle of a detent
    set_ab(2'b01, 10);
    set_ab(2'b00, 10);
    rst_n = 1'b0;
    enc_a = 1'b1;
    enc_b = 1'b1;
    step_clk(3);
    check("t6_rst_value", value, 0);
    check("t6_rst_up", step_up, 0);
    check("t6_rst_dn", step_down, 0);
    check("t6_rst_press", press, 0);
    check("t6_rst_held", held, 0);
    check("t6_rst_qerr", qerr, 0);
    rst_n = 1'b1;
    step_clk(10);
    snap();
    detent_cw();
    check("t6_post_up", n_up - up0, 1);
    check("t6_post_qerr", n_qerr - qe0, 0);
    check("t6_post_value", value, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rotary_encoder_input.md
Name: rotary_encoder_input

Overview:
Front-end conditioning stage for the clock's rotary encoders and push buttons. Synchronises and debounces one encoder's A/B/switch pins, decodes quadrature into one-cycle step pulses, and maintains a wrap-around set value (0..MAX_VAL). It feeds the clock/alarm core directly, replacing raw KEY edges and switch-bank set inputs. Two instances (hours, minutes) sit beside the clock core in the top level.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a level change (5 ms at 50 MHz); minimum 2
DETENT_STEPS, 4, valid quadrature transitions per mechanical detent; legal values 1, 2 or 4
MAX_VAL, 59, upper bound of VALUE; VALUE wraps MAX_VAL<->0
VAL_W, 8, width of VALUE/LOAD_VAL; MAX_VAL < 2^VAL_W

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
RESET_N  in  1  synchronous reset, active-low
ENC_A  in  1  raw encoder phase A, asynchronous, idle high
ENC_B  in  1  raw encoder phase B, asynchronous, idle high
ENC_SW  in  1  raw encoder push switch, asynchronous, active-low
LOAD_EN  in  1  load VALUE from LOAD_VAL this cycle
LOAD_VAL  in  VAL_W  value to load (e.g. current hours on entering set mode)
STEP_UP  out  1  one-cycle pulse per clockwise detent
STEP_DOWN  out  1  one-cycle pulse per counter-clockwise detent
PRESS  out  1  one-cycle pulse on debounced switch press
HELD  out  1  debounced switch level, 1 = pressed
QERR  out  1  one-cycle pulse on illegal quadrature transition
VALUE  out  VAL_W  current set value

Behaviour:
- Reset (RESET_N low at a rising edge): sync and debounced registers = 1, debounce counters = 0, quadrature accumulator = 0, last state = 2'b11; STEP_UP/STEP_DOWN/PRESS/QERR/HELD = 0, VALUE = 0. Reset mid-rotation discards the partial accumulation.
- Synchronisers: 2-FF per pin.
- Debounce, per pin: counter clears whenever the synced input equals the debounced value. Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1 the debounced value takes the synced value and the counter clears. A glitch shorter than DEBOUNCE_CYCLES cycles never propagates.
- Latency: a pin change held stable produces its debounced change DEBOUNCE_CYCLES+2 edges later. The resulting STEP/PRESS pulse and the VALUE update occur on the next edge (total DEBOUNCE_CYCLES+3).
- Quadrature decode on debounced {A,B}, Gray order 11->01->00->10->11 = +1 per transition (clockwise); reverse order = -1.
  - Both bits changing in one cycle: QERR pulse, accumulator cleared, last state updated.
  - Accumulator is signed, range -DETENT_STEPS..+DETENT_STEPS.
  - At +DETENT_STEPS: STEP_UP pulse, accumulator cleared. At -DETENT_STEPS: STEP_DOWN pulse, accumulator cleared.
  - Entering rest state 11 with |acc| < DETENT_STEPS: accumulator cleared (resync after a partial turn), no pulse.
- Switch: PRESS pulses for one cycle on a debounced 1->0 edge of ENC_SW; no pulse on release. HELD = ~debounced ENC_SW.
- VALUE update, highest priority first:
  1. LOAD_EN: VALUE = min(LOAD_VAL, MAX_VAL). A step pulse in the same cycle is dropped.
  2. STEP_UP: VALUE = (VALUE==MAX_VAL) ? 0 : VALUE+1.
  3. STEP_DOWN: VALUE = (VALUE==0) ? MAX_VAL : VALUE-1.
- STEP_UP and STEP_DOWN are never asserted together.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package enc_pkg: Gray state constants (ENC_REST=2'b11, ENC_S1=2'b01, ENC_S2=2'b00, ENC_S3=2'b10), direction encoding (DIR_NONE, DIR_CW, DIR_CCW, DIR_ERR), and a function mapping {last, current} to direction.
- Sub-module debounce_filter (2-FF sync + stable counter, parameter DEBOUNCE_CYCLES, ports CLOCK_50, RESET_N, IN_RAW, OUT_DB), instantiated three times.

Test Plan:
(Bench overrides DEBOUNCE_CYCLES=4, DETENT_STEPS=4, MAX_VAL=59.)
1. Reset, then one clockwise detent (11->01->00->10->11, each state held 10 cycles) -> exactly one STEP_UP pulse, VALUE 0->1. STEP_UP is high for one cycle, 7 edges after the final 11 is applied at the pins.
2. LOAD_EN with LOAD_VAL=59, then one clockwise detent -> VALUE 59->0. Then one counter-clockwise detent -> STEP_DOWN, VALUE 0->59.
3. ENC_A glitch low for 3 cycles, and separately ENC_SW bounce (toggle every 2 cycles for 20 cycles, then low held 10 cycles) -> glitch: no STEP, no QERR, VALUE unchanged; bounce: exactly one PRESS pulse, HELD=1, then HELD=0 after release with no second PRESS.
4. Half turn (11->01->00) then back (00->01->11) -> no STEP pulse, accumulator cleared. A following full clockwise detent gives exactly one STEP_UP.
5. Debounced {A,B} jumps 11->00 -> one QERR pulse, no STEP, VALUE unchanged. LOAD_EN with LOAD_VAL=200 -> VALUE=59.
6. LOAD_EN asserted in the same cycle as a STEP_UP pulse with LOAD_VAL=30 -> VALUE=30, not 31. RESET_N low mid-detent (after 11->01->00) -> all outputs 0, VALUE=0. A full detent after reset gives exactly one STEP_UP.
